// File: rtl/seq_mux_if.sv
// Channel bank, select controls and valid/ready output stage of seq_mux.
// The master drives the channels and controls. The slave is the mux itself.
interface seq_mux_if #(
  parameter int NUM_INP = 32,
  parameter int WIDTH   = 2
);
  localparam int SEL_W = $clog2(NUM_INP);

  logic [NUM_INP*WIDTH-1:0] inp;
  logic [SEL_W-1:0]         sel;
  logic                     mode;
  logic                     in_valid;
  logic                     scan_start;
  logic [SEL_W-1:0]         scan_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out;
  logic [SEL_W-1:0]         out_ch;
  logic                     sel_err;
  logic                     busy;

  modport master (
    output inp, sel, mode, in_valid, scan_start, scan_last, out_ready,
    input  out_valid, out, out_ch, sel_err, busy
  );

  modport slave (
    input  inp, sel, mode, in_valid, scan_start, scan_last, out_ready,
    output out_valid, out, out_ch, sel_err, busy
  );
endinterface

// File: rtl/seq_mux.sv
// Registered N-to-1 channel selector with a valid/ready output stage.
// Direct mode loads one selected channel per request; scan mode streams channels 0..last.
module seq_mux #(
  parameter int NUM_INP = 32,
  parameter int WIDTH   = 2
) (
  input  logic      clk,
  input  logic      reset,
  seq_mux_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_INP);
  localparam logic [SEL_W:0]   NUM_INP_C = (SEL_W+1)'(NUM_INP);
  localparam logic [SEL_W-1:0] LAST_MAX  = SEL_W'(NUM_INP - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             sel_err_q, sel_err_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             can_load;
  logic             sel_ok;
  logic [SEL_W-1:0] mux_idx;
  logic [WIDTH-1:0] mux_data;

  assign can_load = !out_valid_q || bus.out_ready;
  assign sel_ok   = {1'b0, bus.sel} < NUM_INP_C;
  assign mux_idx  = (state_q == SCAN) ? ptr_q : bus.sel;

  // An index with no matching channel selects zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_INP; k++) begin
      if (mux_idx == SEL_W'(k)) begin
        mux_data = bus.inp[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    sel_err_d   = sel_err_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.mode) begin
          if (bus.scan_start) begin
            state_d = SCAN;
            ptr_d   = '0;
            last_d  = (bus.scan_last > LAST_MAX) ? LAST_MAX : bus.scan_last;
            busy_d  = 1'b1;
          end
        end else if (bus.in_valid && can_load) begin
          out_d       = sel_ok ? mux_data : '0;
          out_ch_d    = bus.sel;
          sel_err_d   = !sel_ok;
          out_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (can_load) begin
          out_d       = mux_data;
          out_ch_d    = ptr_q;
          sel_err_d   = 1'b0;
          out_valid_d = 1'b1;
          if (ptr_q == last_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      sel_err_q   <= sel_err_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_mux.sv
// Directed bench for seq_mux using 32-, 30- and 20-channel instances.
// Expected values are hand-derived from the channel pattern inp[k] = k % 4.
module tb_seq_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_count = 0;
  int   check_count = 0;

  always #5 clk = ~clk;

  seq_mux_if #(.NUM_INP(32), .WIDTH(2)) b32 ();
  seq_mux_if #(.NUM_INP(30), .WIDTH(2)) b30 ();
  seq_mux_if #(.NUM_INP(20), .WIDTH(2)) b20 ();

  seq_mux #(.NUM_INP(32), .WIDTH(2)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
  seq_mux #(.NUM_INP(30), .WIDTH(2)) u30 (.clk(clk), .reset(reset), .bus(b30.slave));
  seq_mux #(.NUM_INP(20), .WIDTH(2)) u20 (.clk(clk), .reset(reset), .bus(b20.slave));

  int rdy_seq  [6] = '{1, 0, 1, 1, 0, 1};
  int ch_seq   [6] = '{0, 0, 1, 2, 2, 3};
  int busy_seq [6] = '{1, 1, 1, 1, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Data fields are compared only when a sample is expected, or when full is set.
  task automatic check_port(input string tag, input bit full,
                            input logic o_valid, input logic [1:0] o_out, input logic [4:0] o_ch,
                            input logic o_err, input logic o_busy,
                            input logic e_valid, input logic [1:0] e_out, input logic [4:0] e_ch,
                            input logic e_err, input logic e_busy);
    check({tag, ".out_valid"}, 32'(o_valid), 32'(e_valid));
    check({tag, ".busy"}, 32'(o_busy), 32'(e_busy));
    if (full || e_valid) begin
      check({tag, ".out"}, 32'(o_out), 32'(e_out));
      check({tag, ".out_ch"}, 32'(o_ch), 32'(e_ch));
      check({tag, ".sel_err"}, 32'(o_err), 32'(e_err));
    end
  endtask

  task automatic chk32(input string tag, input bit full, input logic ev, input logic [1:0] eo,
                       input logic [4:0] ec, input logic ee, input logic eb);
    check_port(tag, full, b32.out_valid, b32.out, b32.out_ch, b32.sel_err, b32.busy, ev, eo, ec, ee, eb);
  endtask

  task automatic chk30(input string tag, input logic ev, input logic [1:0] eo,
                       input logic [4:0] ec, input logic ee, input logic eb);
    check_port(tag, 1'b0, b30.out_valid, b30.out, b30.out_ch, b30.sel_err, b30.busy, ev, eo, ec, ee, eb);
  endtask

  task automatic chk20(input string tag, input logic ev, input logic [1:0] eo,
                       input logic [4:0] ec, input logic ee, input logic eb);
    check_port(tag, 1'b0, b20.out_valid, b20.out, b20.out_ch, b20.sel_err, b20.busy, ev, eo, ec, ee, eb);
  endtask

  initial begin
    b32.mode = 1'b0; b32.in_valid = 1'b0; b32.scan_start = 1'b0;
    b32.sel = '0; b32.scan_last = '0; b32.out_ready = 1'b1;
    b30.mode = 1'b0; b30.in_valid = 1'b0; b30.scan_start = 1'b0;
    b30.sel = '0; b30.scan_last = '0; b30.out_ready = 1'b1;
    b20.mode = 1'b0; b20.in_valid = 1'b0; b20.scan_start = 1'b0;
    b20.sel = '0; b20.scan_last = '0; b20.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) b32.inp[k*2 +: 2] = 2'(k % 4);
    for (int k = 0; k < 30; k++) b30.inp[k*2 +: 2] = 2'(k % 4);
    for (int k = 0; k < 20; k++) b20.inp[k*2 +: 2] = 2'(k % 4);

    // Reset state.
    tick();
    tick();
    chk32("reset", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Direct sweep, one sample per cycle.
    for (int k = 0; k < 32; k++) begin
      b32.sel = 5'(k);
      b32.in_valid = 1'b1;
      tick();
      chk32($sformatf("sweep%0d", k), 1'b0, 1'b1, 2'(k % 4), 5'(k), 1'b0, 1'b0);
    end
    b32.in_valid = 1'b0;
    tick();
    chk32("sweep_drain", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);

    // Backpressure holds the sample against later inp/sel changes.
    b32.inp[10 +: 2] = 2'd3;
    b32.inp[14 +: 2] = 2'd2;
    b32.out_ready = 1'b0;
    b32.sel = 5'd5;
    b32.in_valid = 1'b1;
    tick();
    chk32("bp_load", 1'b0, 1'b1, 2'd3, 5'd5, 1'b0, 1'b0);
    b32.inp[10 +: 2] = 2'd1;
    b32.sel = 5'd7;
    tick();
    chk32("bp_hold1", 1'b0, 1'b1, 2'd3, 5'd5, 1'b0, 1'b0);
    tick();
    chk32("bp_hold2", 1'b0, 1'b1, 2'd3, 5'd5, 1'b0, 1'b0);
    b32.out_ready = 1'b1;
    tick();
    chk32("bp_next", 1'b0, 1'b1, 2'd2, 5'd7, 1'b0, 1'b0);
    b32.in_valid = 1'b0;
    tick();
    chk32("bp_drain", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    b32.inp[14 +: 2] = 2'd3;

    // Scan of channels 0..3 with stalls; requests during busy must be ignored.
    b32.mode = 1'b1;
    b32.scan_last = 5'd3;
    b32.scan_start = 1'b1;
    tick();
    chk32("scan_start", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
    b32.scan_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b32.out_ready = 1'(rdy_seq[i]);
      if (i == 1 || i == 2) begin
        b32.in_valid = 1'b1;
        b32.sel = 5'd9;
        b32.scan_start = 1'b1;
        b32.scan_last = 5'd0;
        b32.mode = (i == 2) ? 1'b0 : 1'b1;
      end else begin
        b32.in_valid = 1'b0;
        b32.scan_start = 1'b0;
        b32.mode = 1'b1;
      end
      tick();
      chk32($sformatf("scan_step%0d", i), 1'b0, 1'b1, 2'(ch_seq[i] % 4), 5'(ch_seq[i]),
            1'b0, 1'(busy_seq[i]));
    end
    b32.out_ready = 1'b1;
    tick();
    chk32("scan_done", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    b32.mode = 1'b0;

    // Scan clamp: scan_last beyond the last channel.
    b20.mode = 1'b1;
    b20.scan_last = 5'd31;
    b20.scan_start = 1'b1;
    tick();
    chk20("clamp_start", 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
    b20.scan_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk20($sformatf("clamp%0d", k), 1'b1, 2'(k % 4), 5'(k), 1'b0, (k == 19) ? 1'b0 : 1'b1);
    end
    tick();
    chk20("clamp_idle", 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);

    // Out-of-range selects still deliver a flagged zero sample.
    b30.sel = 5'd30;
    b30.in_valid = 1'b1;
    tick();
    chk30("oor30", 1'b1, 2'd0, 5'd30, 1'b1, 1'b0);
    b30.sel = 5'd31;
    tick();
    chk30("oor31", 1'b1, 2'd0, 5'd31, 1'b1, 1'b0);
    b30.sel = 5'd29;
    tick();
    chk30("inrange29", 1'b1, 2'd1, 5'd29, 1'b0, 1'b0);
    b30.in_valid = 1'b0;
    tick();
    chk30("oor_drain", 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);

    // Reset in the middle of an 8-channel scan.
    b32.mode = 1'b1;
    b32.scan_last = 5'd7;
    b32.scan_start = 1'b1;
    tick();
    b32.scan_start = 1'b0;
    tick();
    tick();
    tick();
    chk32("mid_ch2", 1'b0, 1'b1, 2'd2, 5'd2, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk32("mid_reset", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk32("post_reset", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    b32.mode = 1'b0;
    b32.sel = 5'd3;
    b32.in_valid = 1'b1;
    tick();
    chk32("post_reset_load", 1'b0, 1'b1, 2'd3, 5'd3, 1'b0, 1'b0);
    b32.in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/seq_mux.md
# seq_mux

Parametrised, registered N-to-1 multiplexer with a valid/ready output stage and an auto-scan sequencer. It is the next-generation channel selector for the mux datapath. It adds configurable channel count and width, explicit out-of-range select reporting, backpressure, and a mode that streams channels 0..scan_last out one sample per accepted cycle. It sits between a bank of parallel input channels and a single downstream consumer.

## Interface
Parameters:
- NUM_INP, 32, number of input channels (2..256)
- WIDTH, 2, bits per channel
- SEL_W, $clog2(NUM_INP), select/channel-index width; derived, not overridden

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- inp  in  NUM_INP*WIDTH  flattened channels; channel k = inp[k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select, direct mode
- mode  in  1  0 = direct, 1 = scan
- in_valid  in  1  direct-mode load request
- scan_start  in  1  starts a scan (mode=1, FSM IDLE)
- scan_last  in  SEL_W  last channel of scan, sampled at scan_start
- out_valid  out  1  output register holds a sample
- out_ready  in  1  consumer accepts sample
- out  out  WIDTH  selected sample
- out_ch  out  SEL_W  channel index that produced out
- sel_err  out  1  sample came from out-of-range sel (sel >= NUM_INP)
- busy  out  1  scan in progress

## Operation
- Single output register {out, out_ch, sel_err, out_valid}.
- can_load = !out_valid | out_ready.
- Direct mode (mode=0, FSM IDLE): when in_valid & can_load:
  - sel < NUM_INP: load out=inp[sel], out_ch=sel, sel_err=0.
  - sel >= NUM_INP (reachable for non-power-of-two NUM_INP): load out=0, out_ch=sel, sel_err=1. The sample is still delivered, never dropped.
- in_valid while !can_load: no load. The requester holds in_valid; there is no internal queue.
- Scan FSM, states IDLE and SCAN:
  - IDLE -> SCAN on scan_start & mode=1. Sets ptr=0 and last=min(scan_last, NUM_INP-1). busy=1 from the next cycle.
  - SCAN: each cycle with can_load, load out=inp[ptr], out_ch=ptr, sel_err=0. If ptr==last, go to IDLE (busy=0 next cycle); otherwise ptr++.
  - SCAN with !can_load: hold ptr, no load.
- While busy: in_valid, scan_start, mode and scan_last are ignored. A scan always completes with exactly last+1 samples, channels in ascending order.
- scan_start with mode=0, or while busy: ignored.
- Consumption: out_valid & out_ready with no same-cycle load clears out_valid. A load in the same cycle replaces the sample, and out_valid stays 1.
- While out_valid & !out_ready: out, out_ch and sel_err are held stable.

## Timing
- Latency: load decision in cycle t, sample visible on out/out_valid at t+1.
- Throughput: 1 sample/cycle with out_ready held high, in both modes.
- inp is sampled only in the load cycle; later changes do not affect a held sample.
- busy rises the cycle after the scan_start edge and falls the cycle after the final load.
- Reset (asynchronous, any time, including mid-scan):
  - out_valid=0, out=0, out_ch=0, sel_err=0, busy=0, FSM=IDLE, ptr=0.
  - A scan in progress is aborted and emits no further samples.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- Direct sweep, NUM_INP=32, WIDTH=2, out_ready=1: drive inp[k]=k%4 and sel=0..31 with in_valid=1 on consecutive cycles. Required: 32 samples, one per cycle, each out_ch=k, out=k%4, sel_err=0.
- Out-of-range select, NUM_INP=30: sel=30 then sel=31. Required: two samples with out=0, sel_err=1, out_ch=30 and 31. A following sel=29 gives inp[29] with sel_err=0.
- Backpressure: with out_ready=0, load sel=5 (inp[5]=3), then change inp[5] to 1 and sel to 7. Required: out=3, out_ch=5 held stable. After out_ready=1, the next sample is inp[7].
- Scan with stall: scan_start, scan_last=3, out_ready toggling 1,0,1,1,0,1. Required: exactly 4 samples with out_ch 0,1,2,3. in_valid and scan_start pulses during busy are ignored. busy=0 after the ch3 load.
- Scan clamp: scan_last=31 with NUM_INP=20. Required: 20 samples, ch0..ch19, then IDLE.
- Reset mid-scan: assert reset after ch2 of an 8-channel scan. Required: all outputs 0 immediately. After release, no samples appear until a new request.
